// File: rtl/fpadd_pkg.sv
// Shared constants and payload types for the shared floating-point adder scheduler.
package fpadd_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned ID_W_DEF  = 2;
  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef struct packed {
    logic [FP_W-1:0] src1;
    logic [FP_W-1:0] src2;
  } fp_ops_t;

endpackage

// File: rtl/fpadd_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, increasing index, wrapping at N-1.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fpadder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module fpadder
  import fpadd_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  logic [31:0] x, z;
  logic [7:0]  ex, ez, d;
  logic [27:0] ax, az0, az, mask, s;
  logic [9:0]  e;
  logic [4:0]  lz, sh;
  logic [24:0] m;
  logic        sub, up;

  always_comb begin
    // x is the operand with the larger magnitude; result takes its sign
    x    = (a[30:0] >= b[30:0]) ? a : b;
    z    = (a[30:0] >= b[30:0]) ? b : a;
    ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ez   = (z[30:23] == 8'd0) ? 8'd1 : z[30:23];
    d    = ex - ez;
    ax   = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
    az0  = {1'b0, z[30:23] != 8'd0, z[22:0], 3'b000};
    mask = '0;
    az   = '0;
    if (d > 8'd27) begin
      az = {27'd0, |az0};
    end else begin
      mask = (28'd1 << d) - 28'd1;
      az   = (az0 >> d) | {27'd0, |(az0 & mask)};
    end
    sub = x[31] ^ z[31];
    s   = sub ? (ax - az) : (ax + az);
    e   = {2'b00, ex};
    lz  = '0;
    sh  = '0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i <= 26; i++) begin
        if (s[i]) lz = 5'(26 - i);
      end
      // never normalise below the minimum exponent; leaves a subnormal
      sh = (10'(lz) >= e) ? 5'(e - 10'd1) : lz;
      s  = s << sh;
      e  = e - 10'(sh);
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[26:3]} + 25'(up);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (x[30:23] == 8'hFF)  y = x;
    else if (s == 28'd0)    y = {x[31] & z[31], 31'd0};
    else if (e >= 10'd255)  y = {x[31], 8'hFF, 23'd0};
    else                    y = {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
  end

endmodule

// File: rtl/fpadd_scheduler.sv
// Shares one fpadder among N_REQ requesters: round-robin grant, operand stage S1, result stage S2.
module fpadd_scheduler
  import fpadd_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = ID_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [FP_W*N_REQ-1:0]    req_src1,
  input  logic [FP_W*N_REQ-1:0]    req_src2,
  input  logic [TAG_W*N_REQ-1:0]   req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FP_W-1:0]          rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             s1_v, s2_v;
  fp_ops_t          s1_ops, sel_ops;
  logic [TAG_W-1:0] s1_tag, s2_tag, sel_tag;
  logic [PTR_W-1:0] s1_id, rr_ptr, gnt_idx, ptr_next;
  logic [ID_W-1:0]  s2_id;
  logic [FP_W-1:0]  s2_data, sum;
  logic             s2_adv, s1_adv, any_req, accept;

  // A stage may take new data when it is empty or its content moves on this cycle
  assign s2_adv = !s2_v || rsp_ready;
  assign s1_adv = !s1_v || s2_adv;
  assign accept = s1_adv && any_req;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_adv),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  always_comb begin
    sel_ops.src1 = req_src1[FP_W*gnt_idx +: FP_W];
    sel_ops.src2 = req_src2[FP_W*gnt_idx +: FP_W];
    sel_tag      = req_tag[TAG_W*gnt_idx +: TAG_W];
    ptr_next     = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  fpadder u_fpadder (
    .a (s1_ops.src1),
    .b (s1_ops.src2),
    .y (sum)
  );

  // S1 operand stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_ops <= '0;
      s1_tag <= '0;
      s1_id  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_ops <= sel_ops;
      s1_tag <= sel_tag;
      s1_id  <= gnt_idx;
      rr_ptr <= ptr_next;
    end else if (s1_adv) begin
      s1_v   <= 1'b0;
    end
  end

  // S2 result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_id   <= '0;
      s2_tag  <= '0;
    end else if (s1_v && s2_adv) begin
      s2_v    <= 1'b1;
      s2_data <= sum;
      s2_id   <= ID_W'(s1_id);
      s2_tag  <= s1_tag;
    end else if (rsp_ready) begin
      s2_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_count <= '0;
    else if (s2_v && rsp_ready)  op_count <= op_count + CNT_W'(1);
  end

  assign rsp_valid = s2_v;
  assign rsp_data  = s2_data;
  assign rsp_id    = s2_id;
  assign rsp_tag   = s2_tag;
  assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Scoreboard bench for fpadd_scheduler: grants push expected results, a monitor pops on each response.
module tb_fpadd_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_src1, req_src2;
  logic [15:0]  req_tag;
  logic         rsp_valid, rsp_ready, busy;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic [3:0]   rsp_tag;
  logic [15:0]  op_count;

  logic [31:0]  op_a[4], op_b[4], op_y[4];
  logic [3:0]   op_t[4];
  logic [37:0]  sb[$];
  logic [37:0]  held;
  logic         held_v = 1'b0;
  int           n_tests = 0, n_fail = 0, n_acc = 0, n_done = 0;

  localparam int TARGET = 65535;

  always #5 clk = ~clk;

  fpadd_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .busy      (busy),
    .op_count  (op_count)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_src1[32*i +: 32] = op_a[i];
      req_src2[32*i +: 32] = op_b[i];
      req_tag[4*i +: 4]    = op_t[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input logic [3:0] t);
    op_a[i] = a; op_b[i] = b; op_y[i] = y; op_t[i] = t;
  endtask

  task automatic issue(input int i);
    bit got = 1'b0;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1'b1; break; end
    end
    if (!got) check("grant_timeout", 64'(req_ready), 64'(1 << i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) begin idle = 1'b1; break; end
    end
    if (!idle) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Every granted request predicts its response
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          sb.push_back({op_y[i], 2'(i), op_t[i]});
          n_acc++;
        end
      end
    end
  end

  // Response monitor: ordering, payload and stability while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("rsp_hold", 64'({rsp_valid, rsp_data, rsp_id, rsp_tag}), 64'({1'b1, held}));
      held_v = rsp_valid && !rsp_ready;
      held   = {rsp_data, rsp_id, rsp_tag};
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'({rsp_data, rsp_id, rsp_tag}), 64'd0);
        end else begin
          check("rsp", 64'({rsp_data, rsp_id, rsp_tag}), 64'(sb.pop_front()));
          n_done++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_bus",   64'({rsp_data, rsp_id, rsp_tag}), 64'd0);
    check("rst_op_count",  64'(op_count),  64'd0);
    #3 rst_n = 1'b1;

    // Single op with latency checks
    rsp_ready = 1'b1;
    set_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'd5);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("lat_after_s1", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_after_s2", 64'({rsp_valid, rsp_data, rsp_id, rsp_tag}), 64'({1'b1, 32'h40000000, 2'd0, 4'd5}));
    @(posedge clk); #1;
    check("single_count", 64'(op_count), 64'd1);
    check("single_done",  64'(rsp_valid), 64'd0);

    // Zero operand, mixed sign, plain add on requesters 1..3 (pointer returns to 0)
    set_op(1, 32'h00000000, 32'h40400000, 32'h40400000, 4'd3);
    set_op(2, 32'h3FC00000, 32'hBF000000, 32'h3F800000, 4'd9);
    set_op(3, 32'h3F800000, 32'h3F000000, 32'h3FC00000, 4'hA);
    issue(1);
    issue(2);
    issue(3);
    wait_idle(20);
    check("count_dir", 64'(op_count), 64'd4);

    // Fairness with all four requesting every cycle
    set_op(0, 32'hBF800000, 32'h3F800000, 32'h00000000, 4'd1);
    set_op(1, 32'h3F800000, 32'hC0000000, 32'hBF800000, 4'd2);
    set_op(2, 32'h40000000, 32'h40000000, 32'h40800000, 4'd4);
    set_op(3, 32'h3FC00000, 32'hBF000000, 32'h3F800000, 4'd8);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_gnt", 64'(req_ready), 64'(1 << (k % 4)));
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle(20);
    check("count_fair", 64'(op_count), 64'd12);

    // Backpressure: two accepts then stall
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_gnt", 64'(req_ready), (k == 0) ? 64'h1 : (k == 1) ? 64'h2 : 64'h0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("bp_busy",  64'(busy), 64'd1);
    check("bp_count", 64'(op_count), 64'd12);
    rsp_ready = 1'b1;
    wait_idle(20);
    check("count_bp", 64'(op_count), 64'd14);

    // Reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    req_valid = '0;
    check("pre_rst_full", 64'({busy, rsp_valid}), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_count", 64'(op_count),  64'd0);
    sb.delete();
    n_acc = 0; n_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    check("rst_first_gnt", 64'(req_ready), 64'h1);

    // Stream until op_count reaches its maximum, then wrap it
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk); #1;
      if (n_acc >= TARGET) break;
    end
    req_valid = '0;
    check("bulk_accepts", 64'(n_acc), 64'(TARGET));
    wait_idle(50);
    check("count_max", 64'(op_count), 64'hFFFF);
    set_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'd6);
    issue(0);
    wait_idle(20);
    check("count_wrap", 64'(op_count), 64'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
